// File: rtl/mips_md_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   MD_WIDTH    default operand width
//   OP_*        op field encodings (bit 1 = divide, bit 0 = unsigned)
//   md_state_e  controller state encoding
package mips_md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mips_md_step.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   acc       in   2*WIDTH  current accumulator
//   operand   in   WIDTH    multiplicand (multiply) or divisor (divide)
//   in_bit    in   1        next multiplier bit (LSB first) or dividend bit (MSB first)
//   div_mode  in   1        0 = shift-add multiply, 1 = restoring divide
//   acc_next  out  2*WIDTH  accumulator after this step
// Multiply: acc upper half is the running partial product, the lower half
// collects product bits shifted out on the right.
// Divide: acc upper half is the partial remainder, the lower half collects
// quotient bits shifted in on the right.
module mips_md_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               in_bit,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Carry out of the add becomes the top product bit after the right shift.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (in_bit ? operand : '0)};

  // Remainder < divisor always, so only the low WIDTH bits of the difference
  // matter once the compare says the subtract succeeds.
  assign shifted = {acc[2*WIDTH-1:WIDTH], in_bit};
  assign fits    = shifted >= {1'b0, operand};
  assign diff    = shifted[WIDTH-1:0] - operand;

  always_comb begin
    acc_next = '0;
    if (div_mode) begin
      acc_next = {(fits ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], fits};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_mult_div.sv
// Iterative multiply/divide unit holding the MIPS HI/LO register pair.
// Ports:
//   clk, rst_n    clock (rising edge) and async active-low reset
//   start, op     launch MULT/MULTU/DIV/DIVU with read_data_1 (rs) / read_data_2 (rt)
//   write_data    MTHI/MTLO data, strobed by hi_we / lo_we (IDLE only)
//   hi, lo        HI/LO registers
//   busy          op in progress (WIDTH+1 cycles)
//   done          one-cycle pulse when an op has just written HI/LO
// state   | meaning
// ST_IDLE | waiting; accepts start or MT writes
// ST_RUN  | one shift-add / shift-subtract step per cycle, WIDTH steps
// ST_FIX  | sign correction, write HI/LO, pulse done
module mips_mult_div
  import mips_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic [WIDTH-1:0] write_data,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e          state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [CW-1:0]      cnt_q;

  logic               in_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               step_bit;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  assign in_signed = ~op[0];
  assign a_neg     = in_signed & read_data_1[WIDTH-1];
  assign b_neg     = in_signed & read_data_2[WIDTH-1];
  assign mag_a     = a_neg ? -read_data_1 : read_data_1;
  assign mag_b     = b_neg ? -read_data_2 : read_data_2;

  // Multiplier bits are consumed LSB first, dividend bits MSB first.
  assign step_bit = op_q[1] ? shreg_q[WIDTH-1] : shreg_q[0];

  mips_md_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .in_bit   (step_bit),
    .div_mode (op_q[1]),
    .acc_next (acc_next)
  );

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      // With a zero divisor every step "fits", so the remainder ends up as the
      // dividend magnitude; sign correction restores the raw rs value. Only the
      // quotient needs forcing.
      hi_res = rem_fix;
      lo_res = (opnd_q == '0) ? '1 : quot_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULT;
      opnd_q   <= '0;
      shreg_q  <= '0;
      acc_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q     <= op;
            opnd_q   <= op[1] ? mag_b : mag_a;
            shreg_q  <= op[1] ? mag_a : mag_b;
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            busy     <= 1'b1;
            state    <= ST_RUN;
          end else begin
            if (hi_we) hi <= write_data;
            if (lo_we) lo <= write_data;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_next;
          shreg_q <= op_q[1] ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= hi_res;
          lo    <= lo_res;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mult_div.sv
module tb_mips_mult_div;
  import mips_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] write_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_bad = 0;
  int lat;

  mips_mult_div #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .write_data  (write_data),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present start for one edge (E0), then count edges until done is seen.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; read_data_1 = a; read_data_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    launch(o, a, b);
    wait_done(c);
    chk({tag, " latency"}, 64'(c), 64'd33);
    chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = OP_MULT; read_data_1 = '0; read_data_2 = '0;
    write_data = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);

    // 1: MULTU max*max, with busy and done-pulse checks
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("t1 busy after E0", 64'(busy), 64'd1);
    wait_done(lat);
    chk("t1 latency", 64'(lat), 64'd33);
    chk("t1 hi", 64'(hi), 64'hFFFF_FFFE);
    chk("t1 lo", 64'(lo), 64'h0000_0001);
    chk("t1 busy at done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("t1 done one cycle", 64'(done), 64'd0);

    // 2: signed multiply and truncating signed divide
    run_op("t2 mult -7*3", OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("t2 div -7/2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("mult -3*-5",   OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);
    run_op("divu 100/7",   OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div -100/0",   OP_DIV,  32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF);

    // 3: divide by zero and the overflow case
    run_op("t3 divu 100/0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("t3 div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // 6: MT writes in IDLE; start beats lo_we
    @(negedge clk);
    hi_we = 1'b1; write_data = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("t6 mthi hi", 64'(hi), 64'h1234_5678);
    chk("t6 mthi lo kept", 64'(lo), 64'h8000_0000);
    chk("t6 mthi done", 64'(done), 64'd0);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; write_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("t6 both hi", 64'(hi), 64'hCAFE_F00D);
    chk("t6 both lo", 64'(lo), 64'hCAFE_F00D);
    @(negedge clk);
    op = OP_MULTU; read_data_1 = 32'd5; read_data_2 = 32'd6; start = 1'b1;
    lo_we = 1'b1; write_data = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    chk("t6 start+mtlo lo", 64'(lo), 64'hCAFE_F00D);
    chk("t6 start+mtlo busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("t6 op latency", 64'(lat), 64'd33);
    chk("t6 op hi", 64'(hi), 64'd0);
    chk("t6 op lo", 64'(lo), 64'd30);

    // 4: start and MTHI mid-RUN are ignored
    launch(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = OP_DIVU; read_data_1 = 32'd99; read_data_2 = 32'd3; start = 1'b1;
    hi_we = 1'b1; write_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    chk("t4 hi held mid-run", 64'(hi), 64'd0);
    wait_done(lat);
    chk("t4 latency", 64'(lat + 6), 64'd33);
    chk("t4 hi", 64'(hi), 64'd3);
    chk("t4 lo", 64'(lo), 64'd0);

    // 5: async reset mid-operation, then a fresh op
    launch(OP_MULT, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5 reset hi", 64'(hi), 64'd0);
    chk("t5 reset lo", 64'(lo), 64'd0);
    chk("t5 reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t5 after reset", OP_MULT, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
